// File: rtl/rng_pkg.sv
// rng_pkg: FSM state encoding and maximal-length Fibonacci tap masks for LFSR widths 3..32.
package rng_pkg;
  typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_e;
  localparam int unsigned MIN_WIDTH = 3;
  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned TRY_BITS  = 8;
  // Bit (k-1) set for each term x^k of the feedback polynomial, excluding the constant term.
  function automatic logic [31:0] max_taps(input int unsigned w);
    logic [31:0] t;
    t = '0;
    case (w)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running Fibonacci LFSR with priority seed load and zero-lock guard.
module lfsr_core #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr
);
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  // A zero seed would lock the register forever, so it is replaced by 1.
  always_comb lfsr_d = seed_we ? ((seed_in == '0) ? WIDTH'(1) : seed_in)
                               : {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  always_ff @(posedge clk) lfsr_q <= rst ? SEED : lfsr_d;
  assign lfsr = lfsr_q;
endmodule

// File: rtl/rng_range.sv
// rng_range: bounded random draw by LFSR rejection sampling, falling back to the limit after MAX_TRIES misses.
module rng_range
  import rng_pkg::*;
#(
  parameter int unsigned      WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS      = 10'h240,
  parameter logic [WIDTH-1:0] SEED      = 10'h001,
  parameter int unsigned      MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] rnd,
  output logic             valid,
  output logic             busy,
  output logic             fallback
);
  localparam logic [TRY_BITS-1:0] TRY_LIM = TRY_BITS'(MAX_TRIES);
  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lfsr, limit_q, limit_d, rnd_q, rnd_d;
  logic [TRY_BITS-1:0] try_q, try_d;
  logic                valid_q, valid_d, fallback_q, fallback_d;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .seed_we (seed_we),
    .seed_in (seed_in),
    .lfsr    (lfsr)
  );
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    try_d      = try_q;
    rnd_d      = rnd_q;
    valid_d    = 1'b0;
    fallback_d = 1'b0;
    if (state_q == IDLE) begin
      if (req) begin
        state_d = DRAW;
        limit_d = limit;
        try_d   = '0;
      end
    end else if (lfsr <= limit_q) begin
      rnd_d   = lfsr;
      valid_d = 1'b1;
      state_d = IDLE;
    end else begin
      // Saturating count so a stuck compare can never wrap back to zero.
      try_d = (try_q == '1) ? try_q : try_q + 1'b1;
      if (try_d >= TRY_LIM) begin
        rnd_d      = limit_q;
        valid_d    = 1'b1;
        fallback_d = 1'b1;
        state_d    = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      try_q      <= '0;
      rnd_q      <= '0;
      valid_q    <= 1'b0;
      fallback_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      try_q      <= try_d;
      rnd_q      <= rnd_d;
      valid_q    <= valid_d;
      fallback_q <= fallback_d;
    end
  end
  assign rnd      = rnd_q;
  assign valid    = valid_q;
  assign fallback = fallback_q;
  assign busy     = (state_q == DRAW);
endmodule
